// File: rtl/sram_bank.sv
// -----------------------------------------------------------------------------
// sram_bank
//
// Word-organised SRAM bank behind the AHB-to-SRAM bridge. Reads are
// combinational from the read address. Writes are byte-masked and synchronous.
// A wait-state FSM drives sram_rdy back to the bridge after every access.
//
// Parameters
//   ADDR_WIDTH   byte address width of raddr/waddr
//   DATA_WIDTH   word width (DATA_WIDTH/8 byte lanes)
//   DEPTH_WORDS  number of words (power of two, >= 2)
//   WAIT_CYCLES  cycles sram_rdy stays low after each access (0 = always ready)
//
// Ports
//   HCLK      in   clock
//   HRESETn   in   asynchronous active-low reset (control state only)
//   re        in   read strobe
//   raddr     in   read byte address
//   rsel      in   read byte lanes (deselected lanes return zero)
//   we        in   write strobe
//   waddr     in   write byte address (word aligned)
//   wdata     in   write data
//   wsel      in   write byte enables
//   rdata     out  read data (combinational, zero when re is low)
//   sram_rdy  out  bank ready
//   oor       out  one-cycle pulse: previous-cycle access was out of range
//
// Optional feature
//   SRAM_RAW_BYPASS_EN  when defined, a read and a write to the same word in
//                       the same cycle return the newly written lanes instead
//                       of the old array contents.
// -----------------------------------------------------------------------------
module sram_bank #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic [DATA_WIDTH/8-1:0] rsel,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wsel,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    sram_rdy,
    output logic                    oor
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = $clog2(DEPTH_WORDS);
    localparam int HI  = OFF + IW;
    localparam int CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic          WAIT_EN    = (WAIT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_RELOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_BUSY  = 1'b1
    } state_e;

    // Expand a per-lane select into a full-width bit mask.
    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [NB-1:0] sel);
        logic [DATA_WIDTH-1:0] m;
        m = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NB; i++) begin
            m[i*8 +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

    // True when any address bit above the word index is set.
    function automatic logic above_depth(input logic [ADDR_WIDTH-1:0] addr);
        return |(addr >> HI);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [IW-1:0]         ridx_s;
    logic [IW-1:0]         widx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  access_s;
    logic                  oor_d;
    logic                  oor_q;
    state_e                state_d;
    state_e                state_q;
    logic [CW-1:0]         cnt_d;
    logic [CW-1:0]         cnt_q;
    logic                  unused_addr_s;

    // Byte-offset bits never select anything; fold them away explicitly.
    assign unused_addr_s = ^{raddr, waddr};

    assign ridx_s   = raddr[HI-1:OFF];
    assign widx_s   = waddr[HI-1:OFF];
    assign access_s = re | we;

    // Byte-masked array write; reset leaves contents alone but blocks a write
    // that coincides with the reset edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            // array contents intentionally preserved across reset
        end else if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wsel[i]) begin
                    mem_q[widx_s][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Combinational read path with optional same-word write forwarding.
    always_comb begin
        rd_word_s = mem_q[ridx_s];
`ifdef SRAM_RAW_BYPASS_EN
        if (re && we && (ridx_s == widx_s)) begin
            rd_word_s = (wdata & lane_mask(wsel)) | (mem_q[ridx_s] & ~lane_mask(wsel));
        end else begin
            rd_word_s = mem_q[ridx_s];
        end
`endif
        if (re) begin
            rdata = rd_word_s & lane_mask(rsel);
        end else begin
            rdata = {DATA_WIDTH{1'b0}};
        end
    end

    // Wait-state next-state logic; every access restarts the countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_READY: begin
                if (access_s && WAIT_EN) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    state_d = ST_READY;
                    cnt_d   = cnt_q;
                end
            end
            ST_BUSY: begin
                if (access_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_RELOAD;
                end else if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_READY;
                    cnt_d   = cnt_q;
                end else begin
                    state_d = ST_BUSY;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Out-of-range detection on whichever strobes are active this cycle.
    always_comb begin
        oor_d = 1'b0;
        if (re && above_depth(raddr)) begin
            oor_d = 1'b1;
        end else if (we && above_depth(waddr)) begin
            oor_d = 1'b1;
        end else begin
            oor_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_READY;
            cnt_q   <= {CW{1'b0}};
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
        end
    end

    assign sram_rdy = (state_q == ST_READY);
    assign oor      = oor_q;

endmodule

// File: tb/tb_sram_bank.sv
module tb_sram_bank;

    logic        HCLK;
    logic        HRESETn;
    logic        re;
    logic [31:0] raddr;
    logic [3:0]  rsel;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    logic [31:0] rdata0;
    logic [31:0] rdata3;
    logic        rdy0;
    logic        rdy3;
    logic        oor0;
    logic        oor3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;   // 0 rdata0, 1 rdy0, 2 rdy3, 3 oor0, 4 rdata3
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    sram_bank #(.WAIT_CYCLES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .re(re), .raddr(raddr), .rsel(rsel),
        .we(we), .waddr(waddr), .wdata(wdata), .wsel(wsel),
        .rdata(rdata0), .sram_rdy(rdy0), .oor(oor0)
    );

    sram_bank #(.WAIT_CYCLES(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .re(re), .raddr(raddr), .rsel(rsel),
        .we(we), .waddr(waddr), .wdata(wdata), .wsel(wsel),
        .rdata(rdata3), .sram_rdy(rdy3), .oor(oor3)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic push(input int kind, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic idle();
        re = 1'b0; raddr = 32'h0; rsel = 4'h0;
        we = 1'b0; waddr = 32'h0; wdata = 32'h0; wsel = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        we = 1'b1; waddr = a; wdata = d; wsel = s;
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] s);
        re = 1'b1; raddr = a; rsel = s;
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    // Monitor: compares every queued expectation at the next sample point.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge HCLK or sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    0:       act = rdata0;
                    1:       act = {31'b0, rdy0};
                    2:       act = {31'b0, rdy3};
                    3:       act = {31'b0, oor0};
                    4:       act = rdata3;
                    default: act = 32'hxxxxxxxx;
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        idle();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        push(1, 32'd1, "rst_rdy0");
        push(2, 32'd1, "rst_rdy3");
        push(3, 32'd0, "rst_oor");
        push(0, 32'h0, "rst_rdata");
        cyc();
        HRESETn = 1'b1;
        cyc();

        // basic write then read
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        cyc(); idle();
        rd(32'h10, 4'hF);
        push(0, 32'hDEADBEEF, "rd_0x10");
        push(3, 32'd0, "oor_inrange");
        cyc(); idle();

        // byte merge and read lane masking
        wr(32'h20, 32'h11223344, 4'hF);
        cyc(); idle();
        wr(32'h20, 32'hAABBCCDD, 4'b0100);
        cyc(); idle();
        rd(32'h20, 4'hF);
        push(0, 32'h11BB3344, "merge_full");
        cyc();
        rd(32'h20, 4'b0011);
        push(0, 32'h00003344, "merge_rsel");
        cyc(); idle();

        // simultaneous read and write to different words
        wr(32'h40, 32'h0BADCAFE, 4'hF);
        rd(32'h20, 4'hF);
        push(0, 32'h11BB3344, "dual_rd");
        cyc(); idle();
        rd(32'h40, 4'hF);
        push(0, 32'h0BADCAFE, "dual_wr");
        cyc(); idle();

        // wait states: single access
        repeat (5) cyc();
        push(2, 32'd1, "rdy3_idle");
        rd(32'h10, 4'hF);
        cyc(); idle();
        for (int i = 1; i <= 5; i++) begin
            push(2, (i >= 4) ? 32'd1 : 32'd0, $sformatf("rdy3_single_c%0d", i));
            push(1, 32'd1, "rdy0_nowait");
            cyc();
        end

        // wait states: second access two cycles later extends the window
        rd(32'h10, 4'hF);
        cyc(); idle();
        for (int i = 1; i <= 6; i++) begin
            if (i == 2) begin
                rd(32'h20, 4'hF);
                push(4, 32'h11BB3344, "rd_during_busy");
            end else begin
                idle();
            end
            push(2, (i == 6) ? 32'd1 : 32'd0, $sformatf("rdy3_double_c%0d", i));
            cyc();
        end
        idle();

        // read and write to the same word in one cycle
        wr(32'h30, 32'h0, 4'hF);
        cyc(); idle();
        wr(32'h30, 32'h12345678, 4'hF);
        rd(32'h30, 4'hF);
`ifdef SRAM_RAW_BYPASS_EN
        push(0, 32'h12345678, "raw_new");
`else
        push(0, 32'h00000000, "raw_old");
`endif
        cyc(); idle();
        rd(32'h30, 4'hF);
        push(0, 32'h12345678, "raw_after");
        cyc(); idle();

        // out-of-range write wraps onto word 1
        wr(32'h4004, 32'hCAFEF00D, 4'hF);
        push(3, 32'd0, "oor_before");
        cyc(); idle();
        rd(32'h0004, 4'hF);
        push(3, 32'd1, "oor_wr_pulse");
        push(0, 32'hCAFEF00D, "wrap_rd");
        cyc(); idle();
        push(3, 32'd0, "oor_wr_clear");
        cyc();

        // out-of-range read wraps onto word 4
        rd(32'h8010, 4'hF);
        push(0, 32'hDEADBEEF, "wrap_rd2");
        cyc(); idle();
        push(3, 32'd1, "oor_rd_pulse");
        cyc();
        push(3, 32'd0, "oor_rd_clear");
        cyc();

        // asynchronous reset in BUSY; write at the reset edge is dropped
        repeat (4) cyc();
        wr(32'h50, 32'h55AA55AA, 4'hF);
        cyc(); idle();
        push(2, 32'd0, "rdy3_busy");
        @(negedge HCLK);
        #1;
        wr(32'h10, 32'h0, 4'hF);
        HRESETn = 1'b0;
        #1;
        push(2, 32'd1, "rdy3_async_rst");
        push(3, 32'd0, "oor_async_rst");
        ->sample_ev;
        #1;
        @(posedge HCLK);
        #1;
        idle();
        cyc();
        HRESETn = 1'b1;
        cyc();
        rd(32'h10, 4'hF);
        push(0, 32'hDEADBEEF, "retain_0x10");
        cyc();
        rd(32'h50, 4'hF);
        push(0, 32'h55AA55AA, "retain_0x50");
        cyc(); idle();
        repeat (2) cyc();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_bank.md
# sram_bank

Word-organised single-port-style SRAM bank that sits directly downstream of the AHB-to-SRAM bridge and consumes its read/write strobe interface. Reads are combinational from the read address, writes are byte-masked and synchronous, and a programmable wait-state counter drives `sram_rdy` back to the bridge. The block is the instruction/data memory behind the AHB slave port in simulation and FPGA builds.

## Interface
- `ADDR_WIDTH`, 32: byte address width of `raddr`/`waddr`.
- `DATA_WIDTH`, 32: word width; `DATA_WIDTH/8` byte lanes.
- `DEPTH_WORDS`, 4096: number of words; power of two, ≥2.
- `WAIT_CYCLES`, 0: cycles `sram_rdy` is held low after each accepted access; 0 = never low.
- `HCLK`  in  1  clock.
- `HRESETn`  in  1  asynchronous, active-low reset.
- `re`  in  1  read strobe.
- `raddr`  in  ADDR_WIDTH  read byte address.
- `rsel`  in  DATA_WIDTH/8  read byte lanes; deselected lanes return 0.
- `we`  in  1  write strobe.
- `waddr`  in  ADDR_WIDTH  write byte address (word aligned by the bridge).
- `wdata`  in  DATA_WIDTH  write data.
- `wsel`  in  DATA_WIDTH/8  write byte enables.
- `rdata`  out  DATA_WIDTH  read data.
- `sram_rdy`  out  1  bank ready.
- `oor`  out  1  registered one-cycle pulse: previous-cycle access addressed beyond `DEPTH_WORDS`.

## Operation
- Word index = addr[OFF+IW-1:OFF], OFF = log2(DATA_WIDTH/8), IW = log2(DEPTH_WORDS). Upper bits ignored for indexing (address wraps); any nonzero upper bit on an active strobe sets `oor` next cycle.
- Read: `rdata` = array[index(raddr)] masked per byte by `rsel`, when `re`=1; `rdata` = 0 when `re`=0.
- Write: at posedge with `we`=1, each byte lane i with `wsel[i]`=1 takes `wdata` byte i; other lanes unchanged. `wsel`=0 with `we`=1 is a legal no-op write (still counts as an access).
- Array contents are not reset; reset affects control state only.
- Wait-state FSM, states READY, BUSY; `sram_rdy` = (state == READY).
  - READY: access (`re`|`we`) at a posedge with WAIT_CYCLES>0 → BUSY, cnt = WAIT_CYCLES-1. Otherwise stay.
  - BUSY: access at a posedge → reload cnt = WAIT_CYCLES-1, stay BUSY. Else cnt==0 → READY; else cnt decrements.
  - Accesses during BUSY are fully performed (reads valid, writes committed); only `sram_rdy` is affected.
- With WAIT_CYCLES=0 the FSM stays in READY permanently.
- Simultaneous `re` and `we` to different words: both performed independently.

## Timing
- Read latency 0: `rdata` valid in the same cycle as `re`/`raddr` (bridge registers it at the following edge).
- Write latency 1: data visible to reads from the cycle after the write edge.
- Access at edge N → `sram_rdy` low in cycles N+1 … N+WAIT_CYCLES, high in N+WAIT_CYCLES+1 absent further accesses.
- `oor` asserted in cycle N+1 for the out-of-range access sampled at edge N, for exactly one cycle.
- Reset values: `sram_rdy`=1, FSM=READY, cnt=0, `oor`=0, `rdata`=0 (re low). Reset asserted mid-BUSY returns to READY immediately (asynchronous); an in-flight write at the reset edge is not committed.

## Configuration
- `SRAM_RAW_BYPASS_EN` defined: when `re` and `we` are both 1 and index(raddr)==index(waddr), `rdata` lane i = `wdata` lane i if `wsel[i]`, else array lane i (then masked by `rsel`) — read returns the new data.
- Not defined: same case returns pre-write array contents (old data); no forwarding logic is built.

## Test plan
- Reset, WAIT_CYCLES=0: `sram_rdy`=1, `oor`=0, `rdata`=0; write 0xDEADBEEF to 0x10 with `wsel`=4'hF, read 0x10 next cycle → `rdata`=0xDEADBEEF.
- Byte merge: word 0x20=0x11223344; write `wdata`=0xAABBCCDD, `wsel`=4'b0100 → read 0x20 = 0x11BB3344; read with `rsel`=4'b0011 → 0x00003344.
- WAIT_CYCLES=3: single read at edge N → `sram_rdy` low cycles N+1..N+3, high N+4; second access at N+2 → low through N+5.
- RAW same word, word 0x30=0x0, write 0x12345678 `wsel`=4'hF with `re` to 0x30 → `rdata`=0x12345678 with `SRAM_RAW_BYPASS_EN`, 0x00000000 without.
- DEPTH_WORDS=4096: write to 0x4004 → `oor` pulses one cycle; read 0x0004 returns the written data (wrap).
- Assert HRESETn low during BUSY → `sram_rdy`=1 immediately; previously written words retain contents after reset release.
